// File: rtl/turbo_pkg.sv
`default_nettype none
// ============================================================================
// turbo_pkg : shared types and helpers for the turbo tail terminator
// Revision  : 1.0
// ============================================================================
package turbo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH1 = 2'd1,
        FLUSH2 = 2'd2,
        EMIT   = 2'd3
    } state_t;

    localparam int TERM_SEQ  = 0;
    localparam int TERM_CONC = 1;

    // Output cycles needed to serialise 4*mem tail bits three at a time.
    function automatic int tail_cycles(input int mem);
        return (4 * mem + 2) / 3;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/turbo_tail_term_if.sv
`default_nettype none
// ============================================================================
// turbo_tail_term_if : encoder-side bus of the tail terminator
// Revision           : 1.0
// ============================================================================
interface turbo_tail_term_if;
    logic in_valid;
    logic tail_start;
    logic x1;
    logic z1;
    logic x2;
    logic z2;
    logic term1;
    logic term2;
    logic d0;
    logic d1;
    logic d2;
    logic out_valid;
    logic done;
    logic overrun;

    modport master (
        output in_valid, tail_start, x1, z1, x2, z2,
        input  term1, term2, d0, d1, d2, out_valid, done, overrun
    );

    modport slave (
        input  in_valid, tail_start, x1, z1, x2, z2,
        output term1, term2, d0, d1, d2, out_valid, done, overrun
    );
endinterface
`default_nettype wire

// File: rtl/turbo_tail_term_tail_buffer.sv
`default_nettype none
// ============================================================================
// tail_buffer : 4*MEM-bit tail capture register, column read with zero pad
// Revision    : 1.0
// ============================================================================
module tail_buffer
    import turbo_pkg::*;
#(
    parameter int MEM = 3,
    parameter int CW  = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          we1_i,
    input  wire logic          we2_i,
    input  wire logic [CW-1:0] wr_k_i,
    input  wire logic          x1_i,
    input  wire logic          z1_i,
    input  wire logic          x2_i,
    input  wire logic          z2_i,
    input  wire logic [CW-1:0] rd_j_i,
    output logic      [2:0]    col_o
);
    localparam int W     = 4 * MEM;
    localparam int NTAIL = tail_cycles(MEM);
    localparam int PW    = 3 * NTAIL;
    localparam int WI    = $clog2(W);
    localparam int PI    = $clog2(PW);

    logic [W-1:0]  buf_q;
    logic [W-1:0]  buf_d;
    logic [WI-1:0] w_idx1;
    logic [WI-1:0] w_idx2;
    logic [PW-1:0] w_pad;
    logic [PI-1:0] w_base;

    always_comb begin
        buf_d  = buf_q;
        w_idx1 = WI'(wr_k_i) << 1;
        w_idx2 = w_idx1 + WI'(2 * MEM);
        if (we1_i) buf_d[w_idx1 +: 2] = {z1_i, x1_i};
        if (we2_i) buf_d[w_idx2 +: 2] = {z2_i, x2_i};
        // Bits beyond 4*MEM read back as zero padding on the last column.
        w_pad          = '0;
        w_pad[W-1:0]   = buf_q;
        w_base         = PI'(rd_j_i) * PI'(3);
        col_o          = w_pad[w_base +: 3];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/turbo_tail_term.sv
`default_nettype none
// ============================================================================
// turbo_tail_term : data pass-through, trellis flush and tail serialiser
// Revision        : 1.0
// ============================================================================
module turbo_tail_term
    import turbo_pkg::*;
#(
    parameter int MEM       = 3,
    parameter int TERM_MODE = 0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    turbo_tail_term_if.slave   bus_io
);
    localparam int NTAIL = tail_cycles(MEM);
    localparam int CW    = $clog2(max2(MEM, NTAIL));
    localparam logic [CW-1:0] C_LAST_K = CW'(MEM - 1);
    localparam logic [CW-1:0] C_LAST_J = CW'(NTAIL - 1);
    localparam bit            C_CONC   = (TERM_MODE == TERM_CONC);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          term1_q, term2_q;
    logic          d0_q, d1_q, d2_q;
    logic          valid_q, done_q, overrun_q;
    logic [2:0]    w_col;
    logic          w_we1, w_we2;

    assign w_we1 = (state_q == FLUSH1);
    assign w_we2 = (state_q == FLUSH2) || (C_CONC && (state_q == FLUSH1));

    // One counter serves as flush index k and as emit column j.
    tail_buffer #(.MEM(MEM), .CW(CW)) u_buf (
        .clk    (clk),
        .reset  (reset),
        .we1_i  (w_we1),
        .we2_i  (w_we2),
        .wr_k_i (cnt_q),
        .x1_i   (bus_io.x1),
        .z1_i   (bus_io.z1),
        .x2_i   (bus_io.x2),
        .z2_i   (bus_io.z2),
        .rd_j_i (cnt_q),
        .col_o  (w_col)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            term1_q   <= 1'b0;
            term2_q   <= 1'b0;
            d0_q      <= 1'b0;
            d1_q      <= 1'b0;
            d2_q      <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            d0_q    <= 1'b0;
            d1_q    <= 1'b0;
            d2_q    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (bus_io.in_valid && (state_q != IDLE)) overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (bus_io.in_valid) begin
                        d0_q    <= bus_io.x1;
                        d1_q    <= bus_io.z1;
                        d2_q    <= bus_io.z2;
                        valid_q <= 1'b1;
                        if (bus_io.tail_start) begin
                            state_q <= FLUSH1;
                            cnt_q   <= '0;
                            term1_q <= 1'b1;
                            term2_q <= C_CONC;
                        end
                    end
                end
                FLUSH1: begin
                    if (cnt_q == C_LAST_K) begin
                        cnt_q   <= '0;
                        term1_q <= 1'b0;
                        if (C_CONC) begin
                            term2_q <= 1'b0;
                            state_q <= EMIT;
                        end else begin
                            term2_q <= 1'b1;
                            state_q <= FLUSH2;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FLUSH2: begin
                    if (cnt_q == C_LAST_K) begin
                        cnt_q   <= '0;
                        term2_q <= 1'b0;
                        state_q <= EMIT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                EMIT: begin
                    {d2_q, d1_q, d0_q} <= w_col;
                    valid_q            <= 1'b1;
                    if (cnt_q == C_LAST_J) begin
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_io.term1     = term1_q;
    assign bus_io.term2     = term2_q;
    assign bus_io.d0        = d0_q;
    assign bus_io.d1        = d1_q;
    assign bus_io.d2        = d2_q;
    assign bus_io.out_valid = valid_q;
    assign bus_io.done      = done_q;
    assign bus_io.overrun   = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_turbo_tail_term.sv
`default_nettype none
// ============================================================================
// tb_turbo_tail_term : scoreboard bench over three parameterisations
// Revision           : 1.0
// ============================================================================
module tb_turbo_tail_term;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic in_valid = 1'b0, tail_start = 1'b0;
    logic x1 = 1'b0, z1 = 1'b0, x2 = 1'b0, z2 = 1'b0;
    int   sel = 0;
    logic mon_en = 1'b0;
    int   nvec = 0;
    int   nfail = 0;

    turbo_tail_term_if if_a ();
    turbo_tail_term_if if_b ();
    turbo_tail_term_if if_c ();

    turbo_tail_term #(.MEM(3), .TERM_MODE(0)) dut_a (.clk(clk), .reset(reset), .bus_io(if_a.slave));
    turbo_tail_term #(.MEM(3), .TERM_MODE(1)) dut_b (.clk(clk), .reset(reset), .bus_io(if_b.slave));
    turbo_tail_term #(.MEM(4), .TERM_MODE(0)) dut_c (.clk(clk), .reset(reset), .bus_io(if_c.slave));

    logic [5:0] drv;
    assign drv = {in_valid, tail_start, x1, z1, x2, z2};
    assign {if_a.in_valid, if_a.tail_start, if_a.x1, if_a.z1, if_a.x2, if_a.z2} = (sel == 0) ? drv : 6'b0;
    assign {if_b.in_valid, if_b.tail_start, if_b.x1, if_b.z1, if_b.x2, if_b.z2} = (sel == 1) ? drv : 6'b0;
    assign {if_c.in_valid, if_c.tail_start, if_c.x1, if_c.z1, if_c.x2, if_c.z2} = (sel == 2) ? drv : 6'b0;

    // mon = {term1, term2, d0, d1, d2, out_valid, done, overrun}
    logic [7:0] mon;
    always_comb begin
        case (sel)
            0:       mon = {if_a.term1, if_a.term2, if_a.d0, if_a.d1, if_a.d2, if_a.out_valid, if_a.done, if_a.overrun};
            1:       mon = {if_b.term1, if_b.term2, if_b.d0, if_b.d1, if_b.d2, if_b.out_valid, if_b.done, if_b.overrun};
            default: mon = {if_c.term1, if_c.term2, if_c.d0, if_c.d1, if_c.d2, if_c.out_valid, if_c.done, if_c.overrun};
        endcase
    end

    typedef struct packed {
        logic [2:0] d;     // {d0, d1, d2}
        logic       done;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    function automatic exp_t mk_exp(input logic [2:0] d, input logic dn, input int c);
        exp_t e;
        e.d = d; e.done = dn; e.cyc = c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            nvec++;
            if (mon[2]) begin
                if (exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_out cyc=%0d got d=%b done=%b, required no output", cyc, mon[5:3], mon[1]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (mon[5:3] !== e.d || mon[1] !== e.done || cyc != e.cyc) begin
                        nfail++;
                        $display("FAIL out_vec got d=%b done=%b cyc=%0d, required d=%b done=%b cyc=%0d",
                                 mon[5:3], mon[1], cyc, e.d, e.done, e.cyc);
                    end
                end
            end else if ({mon[5:3], mon[1]} !== 4'b0) begin
                nfail++;
                $display("FAIL idle_zero cyc=%0d got d=%b done=%b, required d=000 done=0", cyc, mon[5:3], mon[1]);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s cyc=%0d got %b, required %b", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_data(input logic a, input logic b, input logic c, input logic last);
        in_valid = 1'b1; tail_start = last;
        x1 = a; z1 = b; x2 = ~a; z2 = c;
        exp_q.push_back(mk_exp({a, b, c}, 1'b0, cyc + 1));
        tick();
    endtask

    task automatic run_block(input int mem, input int mode, input int ndata,
                             input logic [7:0] fx1, input logic [7:0] fz1,
                             input logic [7:0] fx2, input logic [7:0] fz2,
                             input logic [5:0][2:0] cols, input int ntail,
                             input bit inject_ovr, input bit rst_in_emit);
        int t, nflush, kk;
        for (int i = 0; i < ndata - 1; i++) begin
            logic [2:0] v;
            v = 3'(i);
            send_data(v[0], v[1], v[0] ^ v[2], 1'b0);
        end
        t = cyc;
        send_data(1'b1, 1'b0, 1'b1, 1'b1);
        nflush = (mode == 1) ? mem : 2 * mem;
        for (int k = 0; k < nflush; k++) begin
            if (mode == 1)     check("term_conc", {6'b0, mon[7:6]}, 8'b11);
            else if (k < mem)  check("term_seq1", {6'b0, mon[7:6]}, 8'b10);
            else               check("term_seq2", {6'b0, mon[7:6]}, 8'b01);
            kk = (k < mem) ? k : k - mem;
            in_valid   = inject_ovr && (k == 1);
            tail_start = inject_ovr && (k == 1);
            if (mode == 1) begin
                x1 = fx1[kk]; z1 = fz1[kk]; x2 = fx2[kk]; z2 = fz2[kk];
            end else if (k < mem) begin
                x1 = fx1[kk]; z1 = fz1[kk]; x2 = 1'b1; z2 = 1'b1;
            end else begin
                x1 = 1'b1; z1 = 1'b1; x2 = fx2[kk]; z2 = fz2[kk];
            end
            tick();
        end
        in_valid = 1'b0; tail_start = 1'b0;
        x1 = 1'b0; z1 = 1'b0; x2 = 1'b0; z2 = 1'b0;
        check("term_off", {6'b0, mon[7:6]}, 8'b00);
        for (int j = 0; j < (rst_in_emit ? 1 : ntail); j++)
            exp_q.push_back(mk_exp(cols[j], (j == ntail - 1) && !rst_in_emit, t + 2 + nflush + j));
        if (rst_in_emit) begin
            tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
        end else begin
            repeat (ntail) tick();
        end
    endtask

    localparam logic [5:0][2:0] COLS_M3 = {3'b000, 3'b000, 3'b010, 3'b011, 3'b110, 3'b110};
    localparam logic [5:0][2:0] COLS_M4 = {3'b100, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got timeout, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1 check("reset_state", mon, 8'h00);
        end
        sel = 0;
        mon_en = 1'b1;
        tick();

        // Pass-through, then idle, then tail_start without in_valid.
        send_data(1'b1, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();
        tail_start = 1'b1;
        tick();
        tail_start = 1'b0;
        check("no_false_tail", {6'b0, mon[7:6]}, 8'b00);
        tick();

        run_block(3, 0, 8, 8'b101, 8'b011, 8'b110, 8'b001, COLS_M3, 4, 1'b0, 1'b0);
        check("overrun_clear", {7'b0, mon[0]}, 8'd0);
        // Back-to-back block starts in the done cycle; overrun injected in FLUSH1.
        run_block(3, 0, 2, 8'b101, 8'b011, 8'b110, 8'b001, COLS_M3, 4, 1'b1, 1'b0);
        check("overrun_set", {7'b0, mon[0]}, 8'd1);
        repeat (3) tick();
        check("overrun_sticky", {7'b0, mon[0]}, 8'd1);

        run_block(3, 0, 3, 8'b101, 8'b011, 8'b110, 8'b001, COLS_M3, 4, 1'b0, 1'b1);
        check("reset_emit", mon, 8'h00);
        tick();
        run_block(3, 0, 4, 8'b101, 8'b011, 8'b110, 8'b001, COLS_M3, 4, 1'b0, 1'b0);
        tick();

        sel = 1;
        tick();
        run_block(3, 1, 8, 8'b101, 8'b011, 8'b110, 8'b001, COLS_M3, 4, 1'b0, 1'b0);
        tick();

        sel = 2;
        tick();
        run_block(4, 0, 5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, COLS_M4, 6, 1'b0, 1'b0);
        repeat (4) tick();

        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
`default_nettype wire
